// File: rtl/pipeline_ctrl.sv
// Hazard/sequencing controller for the 5-stage pipeline: load-use stalls,
// taken-branch flushes, debug halt/step/resume, and operand forwarding selects.

module pipeline_ctrl_fwd #(
  parameter int REG_W = 4
) (
  input  logic [REG_W-1:0] src,
  input  logic [REG_W-1:0] ex_regaddr,
  input  logic             ex_wb,
  input  logic             ex_is_load,
  input  logic [REG_W-1:0] mem_regaddr,
  input  logic             mem_wb,
  output logic [1:0]       sel,
  output logic             ld_hit
);
  logic w_nz, w_ex_match, w_mem_match;

  // r0 is hardwired zero, so it never participates in forwarding or hazards
  assign w_nz        = (src != '0);
  assign w_ex_match  = w_nz && ex_wb && (ex_regaddr == src);
  assign w_mem_match = w_nz && mem_wb && (mem_regaddr == src);
  assign ld_hit      = w_ex_match && ex_is_load;

  always_comb begin
    sel = 2'b00;
    if (w_ex_match && !ex_is_load) sel = 2'b01;
    else if (w_mem_match)          sel = 2'b10;
  end
endmodule

module pipeline_ctrl #(
  parameter int REG_W        = 4,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic [REG_W-1:0] ex_regaddr,
  input  logic             ex_wb,
  input  logic             ex_is_load,
  input  logic [REG_W-1:0] mem_regaddr,
  input  logic             mem_wb,
  input  logic             branch_taken,
  input  logic             halt_req,
  input  logic             step_req,
  input  logic             resume_req,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             halted,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);
  localparam int  NSRC      = 2;
  localparam int  FW        = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam bit  HAS_FLUSH = (FLUSH_CYCLES > 1);
  localparam logic [FW-1:0] FRELOAD = FW'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {S_RUN, S_FLUSH, S_HALT, S_STEP} state_t;

  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic ifid_flush;
    logic idex_flush;
  } ctrl_t;

  state_t            r_state, w_state_nxt;
  logic [FW-1:0]     r_fcnt, w_fcnt_nxt;
  logic [CNT_W-1:0]  r_stall_cnt, r_flush_cnt;
  ctrl_t             w_ctrl;
  logic              w_stall_inc, w_flush_inc, w_halted, w_hazard;

  logic [NSRC-1:0][REG_W-1:0] w_src;
  logic [NSRC-1:0]            w_uses;
  logic [NSRC-1:0][1:0]       w_sel;
  logic [NSRC-1:0]            w_ld_hit;

  assign w_src  = {id_rt, id_rs};
  assign w_uses = {id_uses_rt, id_uses_rs};

  for (genvar g = 0; g < NSRC; g++) begin : g_src
    pipeline_ctrl_fwd #(.REG_W(REG_W)) u_fwd (
      .src         (w_src[g]),
      .ex_regaddr  (ex_regaddr),
      .ex_wb       (ex_wb),
      .ex_is_load  (ex_is_load),
      .mem_regaddr (mem_regaddr),
      .mem_wb      (mem_wb),
      .sel         (w_sel[g]),
      .ld_hit      (w_ld_hit[g])
    );
  end

  assign fwd_a    = w_sel[0];
  assign fwd_b    = w_sel[1];
  assign w_hazard = |(w_ld_hit & w_uses);

  always_comb begin
    w_state_nxt = r_state;
    w_fcnt_nxt  = r_fcnt;
    w_ctrl      = '{pc_en: 1'b1, ifid_en: 1'b1, ifid_flush: 1'b0, idex_flush: 1'b0};
    w_stall_inc = 1'b0;
    w_flush_inc = 1'b0;
    w_halted    = 1'b0;
    case (r_state)
      S_RUN, S_STEP: begin
        if (branch_taken) begin
          w_ctrl.ifid_flush = 1'b1;
          w_ctrl.idex_flush = 1'b1;
          w_flush_inc       = 1'b1;
          // A stepped branch flushes only its own cycle
          if (r_state == S_RUN && HAS_FLUSH) begin
            w_state_nxt = S_FLUSH;
            w_fcnt_nxt  = FRELOAD;
          end
        end else if (w_hazard) begin
          w_ctrl.pc_en      = 1'b0;
          w_ctrl.ifid_en    = 1'b0;
          w_ctrl.idex_flush = 1'b1;
          w_stall_inc       = 1'b1;
        end else if (r_state == S_RUN && halt_req) begin
          w_state_nxt = S_HALT;
        end
        if (r_state == S_STEP) w_state_nxt = S_HALT;
      end
      S_FLUSH: begin
        w_ctrl.ifid_flush = 1'b1;
        w_ctrl.idex_flush = 1'b1;
        if (branch_taken) begin
          w_flush_inc = 1'b1;
          w_fcnt_nxt  = FRELOAD;
        end else begin
          w_fcnt_nxt = r_fcnt - FW'(1);
          if (r_fcnt == FW'(1)) w_state_nxt = halt_req ? S_HALT : S_RUN;
        end
      end
      S_HALT: begin
        w_halted          = 1'b1;
        w_ctrl.pc_en      = branch_taken;
        w_ctrl.ifid_en    = 1'b0;
        w_ctrl.idex_flush = 1'b1;
        if (branch_taken) begin
          w_ctrl.ifid_flush = 1'b1;
          w_flush_inc       = 1'b1;
        end else if (resume_req) begin
          w_state_nxt = S_RUN;
        end else if (step_req) begin
          w_state_nxt = S_STEP;
        end
      end
      default: w_state_nxt = S_RUN;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= S_RUN;
      r_fcnt      <= '0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_fcnt  <= w_fcnt_nxt;
      if (w_stall_inc && r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (w_flush_inc && r_flush_cnt != '1) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

  assign pc_en       = w_ctrl.pc_en;
  assign ifid_en     = w_ctrl.ifid_en;
  assign ifid_flush  = w_ctrl.ifid_flush;
  assign idex_flush  = w_ctrl.idex_flush;
  assign halted      = w_halted;
  assign stall_count = r_stall_cnt;
  assign flush_count = r_flush_cnt;
endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
Central hazard and sequencing controller for the 5-stage MIPS pipeline. Generates PC and IF/ID enables, IF/ID and ID/EX flushes, and the operand forwarding selects latched into ID/EX.
Handles three cases: load-use stalls, taken-branch flushes signalled by the execute stage, and a debug halt/step/resume mode. Keeps saturating stall and flush event counters.

Parameters:
REG_W, 4, register address width (matches pipeline regaddr)
FLUSH_CYCLES, 2, total cycles IF/ID+ID/EX flush asserted per taken branch (>=1)
CNT_W, 16, width of stall_count and flush_count

Ports:
clock  input  1  system clock, rising edge
reset  input  1  synchronous, active-high
id_rs  input  REG_W  source A address of instruction in ID
id_rt  input  REG_W  source B address of instruction in ID
id_uses_rs  input  1  ID instruction reads rs
id_uses_rt  input  1  ID instruction reads rt
ex_regaddr  input  REG_W  destination address of instruction in EX
ex_wb  input  1  EX instruction writes register file
ex_is_load  input  1  EX instruction is a load
mem_regaddr  input  REG_W  destination address of instruction in MEM
mem_wb  input  1  MEM instruction writes register file
branch_taken  input  1  registered taken-branch from execute (inverse of use_npc)
halt_req  input  1  debug halt request, level
step_req  input  1  debug single-step request, one-cycle pulse
resume_req  input  1  debug resume request, one-cycle pulse
pc_en  output  1  PC register load enable
ifid_en  output  1  IF/ID register load enable
ifid_flush  output  1  clear IF/ID to NOP
idex_flush  output  1  load bubble into ID/EX
fwd_a  output  2  source A select: 00 regfile, 01 EX result, 10 MEM result
fwd_b  output  2  source B select, same encoding
halted  output  1  controller in HALT state
stall_count  output  CNT_W  load-use stall cycles, saturating
flush_count  output  CNT_W  taken-branch events, saturating

Behaviour:
- Reset: synchronous, active-high, clock clock. State is RUN; stall_count, flush_count and the flush counter are 0. Reset overrides any in-flight flush, halt or step.
- Forwarding is combinational and state-independent. A register address of 0 never matches.
- fwd_a=01 if ex_wb && ex_regaddr==id_rs && !ex_is_load. Otherwise fwd_a=10 if mem_wb && mem_regaddr==id_rs. Otherwise 00. EX has priority over MEM. fwd_b is the same against id_rt.
- hazard = ex_is_load && ex_wb && ex_regaddr!=0 && ((id_uses_rs && ex_regaddr==id_rs) || (id_uses_rt && ex_regaddr==id_rt)).
- States: RUN, FLUSH, HALT, STEP. Combinational outputs, registered state. Event priority: branch_taken > hazard > halt_req.
- pc_en=1 whenever branch_taken=1, in every state, so the jump address is never lost.
- RUN, branch_taken: ifid_flush=1, idex_flush=1, flush_count+1. If FLUSH_CYCLES>1, go to FLUSH with counter=FLUSH_CYCLES-1; otherwise stay in RUN.
- RUN, hazard (no branch): pc_en=0, ifid_en=0, idex_flush=1, stall_count+1, stay in RUN. Exactly one bubble per load-use; the next cycle resolves via MEM forwarding.
- RUN, halt_req (no branch/hazard): normal advance this cycle, then HALT.
- RUN, no event: pc_en=1, ifid_en=1, flushes 0.
- FLUSH: pc_en=1, ifid_en=1, ifid_flush=1, idex_flush=1; counter decrements each cycle. On counter==1, go to RUN, or to HALT if halt_req. A branch_taken in FLUSH reloads counter=FLUSH_CYCLES-1 and increments flush_count.
- HALT: halted=1, pc_en=0 (unless branch), ifid_en=0, idex_flush=1 to drain bubbles. branch_taken in HALT also asserts ifid_flush and flush_count+1, and stays in HALT.
- HALT transitions: resume_req goes to RUN; step_req goes to STEP; resume wins if both arrive in the same cycle.
- STEP: one cycle of RUN-equivalent outputs including hazard and branch handling, then back to HALT. A hazard in STEP consumes the step (bubble only). A branch in STEP flushes for that cycle only.
- Counters saturate at 2^CNT_W-1.

Test Plan:
- Reset held 3 cycles mid-FLUSH -> state RUN, pc_en=1, flushes 0, both counters 0 the cycle after reset deasserts.
- ID rs=3, EX load to r3 with ex_wb=1 -> exactly one cycle pc_en=0, ifid_en=0, idex_flush=1; next cycle fwd_a=10 (mem_regaddr=3), stall_count=1.
- EX ALU writes r5, MEM writes r5, ID rt=5 -> fwd_b=01. With ex_regaddr=0 and id_rs=0 -> fwd_a=00.
- branch_taken pulse in RUN, FLUSH_CYCLES=2 -> ifid_flush and idex_flush high 2 consecutive cycles, pc_en=1, flush_count=1, then RUN.
- halt_req then step_req x2 then resume_req -> halted high; pc_en high exactly one cycle per step; RUN after resume.
- Branch and hazard in same cycle -> flush path taken, stall_count unchanged. Force stall_count to all-ones -> no wrap.
